// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and oversample constants for the UART blocks.
package uart_pkg;

  // Shared by uart_tx and uart_rx; keep the encoding stable.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  // s_tick count at the middle of the start bit.
  localparam int unsigned MidBit = 7;
  // s_tick count at the end of a full bit period.
  localparam int unsigned BitEnd = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the rx pad plus a third flop for
// falling-edge detection. Flops reset high so an idle line never looks like
// a start edge coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic [2:0] sync_q;

  // Shift the raw line through the synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx};
    end
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first, DBIT data bits and a
// stop bit lasting SB_TICK s_ticks. Define UART_RX_PARITY_EN to add a parity
// bit between data and stop (sense selected by PAR_ODD).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PAR_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  // s must reach both BitEnd and SB_TICK-1 without wrapping.
  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = $clog2(DBIT);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .fall    (fall)
  );

  uart_state_e     state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            ferr_q;

`ifdef UART_RX_PARITY_EN
  localparam logic ParOdd = (PAR_ODD != 0);
  logic par_q;
  logic perr_q;
`endif

  // Receive FSM; all outputs are registered and flags only qualify done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // Only a true 1->0 edge starts a frame; a held-low line is ignored.
          if (fall) begin
            state_q <= StStart;
            s_q     <= '0;
          end
        end
        StStart: begin
          if (s_tick) begin
            if (s_q == SW'(MidBit)) begin
              if (!rx_s) begin
                state_q <= StData;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                // Start bit gone high by mid-bit: treat as a glitch.
                state_q <= StIdle;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        StData: begin
          if (s_tick) begin
            if (s_q == SW'(BitEnd)) begin
              b_q <= {rx_s, b_q[DBIT-1:1]};
              s_q <= '0;
              if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (s_tick) begin
            if (s_q == SW'(BitEnd)) begin
              par_q   <= ^b_q ^ rx_s ^ ParOdd;
              s_q     <= '0;
              state_q <= StStop;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
`endif
        StStop: begin
          if (s_tick) begin
            if (s_q == SW'(SB_TICK - 1)) begin
              dout_q  <= b_q;
              ferr_q  <= ~rx_s;
              done_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_q  <= par_q;
`endif
              s_q     <= '0;
              state_q <= StIdle;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  // Parity sense is irrelevant without a parity bit.
  logic unused_par_odd;
  assign unused_par_odd = (PAR_ODD != 0);
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (DBIT=8, SB_TICK=16, s_tick every
// 4 clk so one bit period is 64 clk). Parity steps run with UART_RX_PARITY_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BitClk = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] dq[$];
  logic       fq[$];
  logic       pq[$];
  int         flag_viol = 0;
  int         dbl_done = 0;
  logic       done_prev = 1'b0;
  logic [1:0] tdiv = 2'd0;

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16),
    .PAR_ODD (0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // One s_tick every fourth clock.
  always @(posedge clk) begin
    tdiv   <= tdiv + 2'd1;
    s_tick <= (tdiv == 2'd3);
  end

  // Record every done pulse and watch output invariants away from the edge.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      dq.push_back(dout);
      fq.push_back(frame_err);
      pq.push_back(parity_err);
    end else if (frame_err || parity_err) begin
      flag_viol++;
    end
    if (rx_done_tick && done_prev) dbl_done++;
    done_prev = rx_done_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_clk(BitClk);
  endtask

  // Start, 8 data bits LSB first, optional parity (even sense, flip to
  // corrupt), stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    drive_bit(stop);
  endtask

  initial begin
    int base;
    logic [7:0] v5a;

    // Reset state.
    wait_clk(4);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    reset_n = 1'b1;
    wait_clk(BitClk);

    // 8N1 frame 0xA5.
    send_frame(8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("a5_count", 32'(dq.size()), 32'd1);
    if (dq.size() == 1) begin
      check("a5_dout", 32'(dq[0]), 32'hA5);
      check("a5_ferr", 32'(fq[0]), 32'h0);
      check("a5_perr", 32'(pq[0]), 32'h0);
    end

    // Short low glitch of 4 s_ticks.
    rx = 1'b0;
    wait_clk(16);
    rx = 1'b1;
    wait_clk(2 * BitClk);
    check("glitch_count", 32'(dq.size()), 32'd1);
    check("glitch_dout", 32'(dout), 32'hA5);
    check("glitch_idle", 32'(dut.state_q), 32'(StIdle));

    // Framing error: stop bit low, line held low three more bit times.
    base = dq.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    wait_clk(3 * BitClk);
    check("ferr_count", 32'(dq.size()), 32'(base + 1));
    if (dq.size() == base + 1) begin
      check("ferr_dout", 32'(dq[base]), 32'h3C);
      check("ferr_flag", 32'(fq[base]), 32'h1);
    end
    drive_bit(1'b1);
    check("ferr_no_retrigger", 32'(dq.size()), 32'(base + 1));

    // Back-to-back 0x00 then 0xFF without an idle gap.
    base = dq.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("b2b_count", 32'(dq.size()), 32'(base + 2));
    if (dq.size() == base + 2) begin
      check("b2b_dout0", 32'(dq[base]), 32'h00);
      check("b2b_dout1", 32'(dq[base+1]), 32'hFF);
      check("b2b_ferr1", 32'(fq[base+1]), 32'h0);
    end

    // Reset pulsed in the middle of data bit 4 of 0x5A.
    base = dq.size();
    v5a = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(v5a[i]);
    rx = v5a[4];
    wait_clk(BitClk / 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", 32'(dout), 32'h00);
    check("mid_rst_done", 32'(rx_done_tick), 32'h0);
    check("mid_rst_ferr", 32'(frame_err), 32'h0);
    wait_clk(3);
    reset_n = 1'b1;
    rx = 1'b1;
    wait_clk(2 * BitClk);
    check("mid_rst_no_done", 32'(dq.size()), 32'(base));
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1);
    check("post_rst_count", 32'(dq.size()), 32'(base + 1));
    if (dq.size() == base + 1) begin
      check("post_rst_dout", 32'(dq[base]), 32'h81);
      check("post_rst_ferr", 32'(fq[base]), 32'h0);
    end

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 1 is correct even parity, 0 is wrong.
    base = dq.size();
    send_frame(8'h07, 1'b1, 1'b0);
    drive_bit(1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1);
    check("par_count", 32'(dq.size()), 32'(base + 2));
    if (dq.size() == base + 2) begin
      check("par_ok_dout", 32'(dq[base]), 32'h07);
      check("par_ok_perr", 32'(pq[base]), 32'h0);
      check("par_bad_perr", 32'(pq[base+1]), 32'h1);
    end
`endif

    // Whole-run invariants.
    check("flags_only_with_done", 32'(flag_viol), 32'd0);
    check("done_single_cycle", 32'(dbl_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
